// File: rtl/encrypter.sv
// -----------------------------------------------------------------------------
// encrypter
//
// Transmit-side block cipher stage. It accepts a plaintext word, swaps its two
// halves and XORs the result with a latched key. The decrypter reverses this
// bit-exactly under the same key:
//   E = {P[W/2-1:0], P[W-1:W/2]} ^ K
//
// Handshakes (both sides): a word moves on a rising clk edge where its valid
// and ready are both high. The producer keeps valid and data stable until that
// edge. The consumer's ready has no effect while valid is low.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   key_load_in      in   load key_in into the key register (IDLE only)
//   key_in           in   key value
//   plain_valid_in   in   plaintext word offered
//   plain_in         in   plaintext word
//   plain_ready_out  out  block can accept plaintext this cycle
//   encrypted_out    out  ciphertext word (registered)
//   enc_valid_out    out  ciphertext valid (registered)
//   enc_ready_in     in   downstream accepts ciphertext
//   busy_out         out  high whenever the FSM is not in IDLE
//   block_count_out  out  completed-block counter
//   state_dbg_out    out  FSM state encoding (0 IDLE, 1 ENCRYPT, 2 OUTPUT)
//
// Optional feature: define ENCRYPTER_BLOCK_CNT_EN to build a 16-bit wrapping
// counter of completed output handshakes. Without it, block_count_out is 0.
// -----------------------------------------------------------------------------
module encrypter #(
  parameter int data_width_g = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_load_in,
  input  logic [data_width_g-1:0] key_in,
  input  logic                    plain_valid_in,
  input  logic [data_width_g-1:0] plain_in,
  output logic                    plain_ready_out,
  output logic [data_width_g-1:0] encrypted_out,
  output logic                    enc_valid_out,
  input  logic                    enc_ready_in,
  output logic                    busy_out,
  output logic [15:0]             block_count_out,
  output logic [1:0]              state_dbg_out
);

  localparam int HalfW = data_width_g / 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENCRYPT = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [data_width_g-1:0] key_q, key_d;
  logic [data_width_g-1:0] data_q, data_d;
  logic [data_width_g-1:0] enc_q, enc_d;
  logic                    valid_q, valid_d;

  // Datapath enables decoded from the state.
  logic key_we;
  logic data_we;
  logic enc_we;
  logic out_hs;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // A key load takes priority: plaintext offered in the same cycle waits.
        if (!key_load_in && plain_valid_in) begin
          state_d = ST_ENCRYPT;
        end
      end
      ST_ENCRYPT: begin
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (enc_ready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath enables
  // ---------------------------------------------------------------------------
  always_comb begin
    plain_ready_out = (state_q == ST_IDLE) && !key_load_in;
    busy_out        = (state_q != ST_IDLE);
    key_we          = (state_q == ST_IDLE) && key_load_in;
    data_we         = (state_q == ST_IDLE) && !key_load_in && plain_valid_in;
    enc_we          = (state_q == ST_ENCRYPT);
    // valid_q is always high in OUTPUT; it is included so that a ready
    // without a valid word can never count as a handshake.
    out_hs          = (state_q == ST_OUTPUT) && valid_q && enc_ready_in;
  end

  assign state_dbg_out = state_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    key_d   = key_q;
    data_d  = data_q;
    enc_d   = enc_q;
    valid_d = valid_q;
    if (key_we) begin
      key_d = key_in;
    end
    if (data_we) begin
      data_d = plain_in;
    end
    if (enc_we) begin
      // Swap exactly HalfW bits per half, then whiten with the key.
      enc_d   = {data_q[HalfW-1:0], data_q[data_width_g-1:HalfW]} ^ key_q;
      valid_d = 1'b1;
    end else if (out_hs) begin
      // encrypted_out keeps the last ciphertext; only valid drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      data_q  <= '0;
      enc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      data_q  <= data_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
    end
  end

  assign encrypted_out = enc_q;
  assign enc_valid_out = valid_q;

  // ---------------------------------------------------------------------------
  // Completed-block counter
  // ---------------------------------------------------------------------------
`ifdef ENCRYPTER_BLOCK_CNT_EN
  logic [15:0] count_q, count_d;

  // Wraps 0xFFFF -> 0x0000 naturally through the 16-bit add.
  always_comb begin
    count_d = count_q;
    if (out_hs) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign block_count_out = count_q;
`else
  assign block_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_encrypter.sv
// -----------------------------------------------------------------------------
// tb_encrypter
//
// Directed testbench for encrypter with hand-computed ciphertext. Inputs are
// driven and outputs sampled on the falling edge of clk. The DUT acts on the
// rising edge.
// -----------------------------------------------------------------------------
module tb_encrypter;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          key_load_in;
  logic [W-1:0]  key_in;
  logic          plain_valid_in;
  logic [W-1:0]  plain_in;
  logic          plain_ready_out;
  logic [W-1:0]  encrypted_out;
  logic          enc_valid_out;
  logic          enc_ready_in;
  logic          busy_out;
  logic [15:0]   block_count_out;
  logic [1:0]    state_dbg_out;

  int vectors;
  int miscompares;

  encrypter #(.data_width_g(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_load_in     (key_load_in),
    .key_in          (key_in),
    .plain_valid_in  (plain_valid_in),
    .plain_in        (plain_in),
    .plain_ready_out (plain_ready_out),
    .encrypted_out   (encrypted_out),
    .enc_valid_out   (enc_valid_out),
    .enc_ready_in    (enc_ready_in),
    .busy_out        (busy_out),
    .block_count_out (block_count_out),
    .state_dbg_out   (state_dbg_out)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks (all return on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_key(input logic [W-1:0] k);
    key_load_in = 1'b1;
    key_in      = k;
    step();
    key_load_in = 1'b0;
  endtask

  // Offer a word in IDLE. On return the word has been taken and the FSM is
  // in ENCRYPT.
  task automatic offer_plain(input logic [W-1:0] p);
    plain_valid_in = 1'b1;
    plain_in       = p;
    step();
    plain_valid_in = 1'b0;
    plain_in       = $urandom();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n          = 1'b0;
    key_load_in    = 1'b0;
    key_in         = '0;
    plain_valid_in = 1'b0;
    plain_in       = '0;
    enc_ready_in   = 1'b0;
    step();
    vectors++;
    if (enc_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", enc_valid_out);
    end
    vectors++;
    if (encrypted_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_enc: got %h want 00000000", encrypted_out);
    end
    vectors++;
    if (plain_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", plain_ready_out);
    end
    vectors++;
    if (busy_out !== 1'b0 || state_dbg_out !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy %b state %0d want 0/0", busy_out, state_dbg_out);
    end
    vectors++;
    if (block_count_out !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_count: got %h want 0000", block_count_out);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [W-1:0] t;
    enc_ready_in = 1'b1;
    load_key(32'hDEADBEEF);
    offer_plain(32'h12345678);
    // ENCRYPT cycle: nothing valid yet, no plaintext accepted
    vectors++;
    if (enc_valid_out !== 1'b0 || busy_out !== 1'b1 || plain_ready_out !== 1'b0 ||
        state_dbg_out !== 2'd1) begin
      miscompares++;
      $display("FAIL basic_encrypt_phase: valid %b busy %b ready %b state %0d want 0/1/0/1",
               enc_valid_out, busy_out, plain_ready_out, state_dbg_out);
    end
    step();
    vectors++;
    if (enc_valid_out !== 1'b1 || encrypted_out !== 32'h88D5ACDB) begin
      miscompares++;
      $display("FAIL basic_cipher: valid %b data %h want 1/88d5acdb", enc_valid_out, encrypted_out);
    end
    // Decrypter view: XOR key, swap halves back
    t = encrypted_out ^ 32'hDEADBEEF;
    t = {t[15:0], t[31:16]};
    vectors++;
    if (t !== 32'h12345678) begin
      miscompares++;
      $display("FAIL basic_roundtrip: got %h want 12345678", t);
    end
    step();
    vectors++;
    if (enc_valid_out !== 1'b0 || busy_out !== 1'b0 || encrypted_out !== 32'h88D5ACDB) begin
      miscompares++;
      $display("FAIL basic_after_hs: valid %b busy %b data %h want 0/0/88d5acdb",
               enc_valid_out, busy_out, encrypted_out);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] keys [2];
    logic [W-1:0] pts  [2];
    logic [W-1:0] exps [2];
    keys[0] = 32'h00000000; pts[0] = 32'hFFFF0000; exps[0] = 32'h0000FFFF;
    keys[1] = 32'hDEADBEEF; pts[1] = 32'h00000000; exps[1] = 32'hDEADBEEF;
    enc_ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_key(keys[i]);
      offer_plain(pts[i]);
      step();
      vectors++;
      if (enc_valid_out !== 1'b1 || encrypted_out !== exps[i]) begin
        miscompares++;
        $display("FAIL vector_%0d: valid %b data %h want 1/%h", i, enc_valid_out, encrypted_out, exps[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    enc_ready_in = 1'b0;
    load_key(32'h0F0F0F0F);
    offer_plain(32'hA5A53C3C);
    step();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (enc_valid_out !== 1'b1 || encrypted_out !== 32'h3333AAAA ||
          plain_ready_out !== 1'b0 || busy_out !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: valid %b data %h ready %b busy %b want 1/3333aaaa/0/1",
                 i, enc_valid_out, encrypted_out, plain_ready_out, busy_out);
      end
      step();
    end
    enc_ready_in = 1'b1;
    step();
    vectors++;
    if (enc_valid_out !== 1'b0 || busy_out !== 1'b0 || plain_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: valid %b busy %b ready %b want 0/0/1",
               enc_valid_out, busy_out, plain_ready_out);
    end
  endtask

  task automatic test_key_collision();
    enc_ready_in   = 1'b1;
    key_load_in    = 1'b1;
    key_in         = 32'h11111111;
    plain_valid_in = 1'b1;
    plain_in       = 32'hFFFFFFFF;
    #1;
    vectors++;
    if (plain_ready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_ready: got %b want 0", plain_ready_out);
    end
    step();
    key_load_in    = 1'b0;
    plain_valid_in = 1'b0;
    vectors++;
    if (busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_not_taken: busy %b want 0", busy_out);
    end
    offer_plain(32'h00000000);
    step();
    vectors++;
    if (encrypted_out !== 32'h11111111) begin
      miscompares++;
      $display("FAIL collide_key: got %h want 11111111", encrypted_out);
    end
    step();
  endtask

  task automatic test_key_in_output();
    // key is 0x11111111 from the previous scenario
    enc_ready_in = 1'b0;
    offer_plain(32'h00010002);
    step();
    key_load_in = 1'b1;
    key_in      = 32'h22222222;
    step();
    key_load_in = 1'b0;
    vectors++;
    if (encrypted_out !== 32'h11131110 || enc_valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL outkey_block: valid %b data %h want 1/11131110", enc_valid_out, encrypted_out);
    end
    enc_ready_in = 1'b1;
    step();
    offer_plain(32'h00000000);
    step();
    vectors++;
    if (encrypted_out !== 32'h11111111) begin
      miscompares++;
      $display("FAIL outkey_unchanged: got %h want 11111111", encrypted_out);
    end
    step();
  endtask

  task automatic test_reset_encrypt();
    enc_ready_in = 1'b0;
    load_key(32'hDEADBEEF);
    offer_plain(32'h12345678);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (enc_valid_out !== 1'b0 || encrypted_out !== 32'h0 || busy_out !== 1'b0 ||
        state_dbg_out !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_enc_async: valid %b data %h busy %b state %0d want 0/0/0/0",
               enc_valid_out, encrypted_out, busy_out, state_dbg_out);
    end
    step();
    rst_n        = 1'b1;
    enc_ready_in = 1'b1;
    step();
    offer_plain(32'h12345678);
    step();
    vectors++;
    if (encrypted_out !== 32'h56781234) begin
      miscompares++;
      $display("FAIL rst_enc_keyclr: got %h want 56781234", encrypted_out);
    end
    step();
  endtask

  task automatic test_reset_output();
    enc_ready_in = 1'b0;
    load_key(32'hDEADBEEF);
    offer_plain(32'h00000000);
    step();
    vectors++;
    if (enc_valid_out !== 1'b1 || encrypted_out !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rst_out_pre: valid %b data %h want 1/deadbeef", enc_valid_out, encrypted_out);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (enc_valid_out !== 1'b0 || encrypted_out !== 32'h0 || busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_out_async: valid %b data %h busy %b want 0/0/0",
               enc_valid_out, encrypted_out, busy_out);
    end
    step();
    rst_n        = 1'b1;
    enc_ready_in = 1'b1;
    step();
    offer_plain(32'h0000ABCD);
    step();
    vectors++;
    if (encrypted_out !== 32'hABCD0000) begin
      miscompares++;
      $display("FAIL rst_out_keyclr: got %h want abcd0000", encrypted_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    do_reset();
    enc_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer_plain($urandom());
      step();
      step();
    end
`ifdef ENCRYPTER_BLOCK_CNT_EN
    want = 16'd10;
`else
    want = 16'd0;
`endif
    vectors++;
    if (block_count_out !== want) begin
      miscompares++;
      $display("FAIL b2b_count: got %h want %h", block_count_out, want);
    end
`ifdef ENCRYPTER_BLOCK_CNT_EN
    force dut.count_q = 16'hFFFF;
    step();
    release dut.count_q;
    offer_plain(32'h00000001);
    step();
    step();
    vectors++;
    if (block_count_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL count_wrap: got %h want 0000", block_count_out);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_key_collision();
    test_key_in_output();
    test_reset_encrypt();
    test_reset_output();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
